fwd_hazard_unit: RTL

Parametrised forwarding and load-use hazard unit for the pipelined datapath. It tracks destination tags of in-flight instructions in an internal shadow pipeline and drives per-operand bypass selects for the instruction in EX. It also generates a load-use stall toward the PC/IF-ID registers. It sits beside the ID/EX boundary and replaces the single-source, single-compare forwarding logic with a multi-stage, priority-ordered version that is aware of register $0.

---
 rtl/fwd_pkg.sv | 37 +++
 rtl/fwd_match.sv | 45 ++++
 rtl/fwd_hazard_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types, constants and helpers for the forwarding / load-use hazard unit.
// Register addresses are carried zero-extended to AW_MAX bits inside the unit.
package fwd_pkg;

  // Widest register-address width the tag struct can carry; AW must not exceed it.
  localparam int AW_MAX = 8;

  // Operand select values: 0 reads the register file, k picks source stage k.
  localparam int SEL_RF    = 0;
  localparam int SRC_EXMEM = 1;
  localparam int SRC_MEMWB = 2;

  typedef logic [AW_MAX-1:0] regAddr_t;

  typedef struct packed {
    logic     v;
    logic     we;
    regAddr_t rd;
    logic     load;
  } fwdTag_t;

  typedef struct packed {
    fwdTag_t  tag;
    regAddr_t rs;
    logic     rsEn;
    regAddr_t rt;
    logic     rtEn;
  } exSlot_t;

  localparam int TAG_W = $bits(fwdTag_t);

  // Register $0 is hard-wired, so a write to it never produces forwardable data.
  function automatic logic writesReg(fwdTag_t t, regAddr_t r);
    return t.v && t.we && (t.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority compare of one operand: bypass select for the EX consumer and an
// "unready load" flag for the same operand field of the instruction in ID.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = $clog2(DEPTH + 1)
) (
  input  logic [AW_MAX-1:0]      exReg,
  input  logic                   exEn,
  input  logic [AW_MAX-1:0]      idReg,
  input  logic                   idEn,
  input  logic [TAG_W-1:0]       exTag,
  input  logic [DEPTH*TAG_W-1:0] srcTags,
  output logic [SELW-1:0]        sel,
  output logic                   loadHazard
);

  fwdTag_t [DEPTH:1] srcArr;
  // Position-indexed view for the ID check: 0 = EX slot, k = src[k].
  fwdTag_t [DEPTH:0] cand;
  logic              nearestIsLoad;

  assign srcArr = srcTags;
  assign cand   = {srcArr, fwdTag_t'(exTag)};

  // Scanning from the oldest stage down lets the youngest match overwrite older ones.
  always_comb begin
    sel = SELW'(SEL_RF);
    for (int k = DEPTH; k >= 1; k--) begin
      if (exEn && writesReg(srcArr[k], exReg)) sel = SELW'(k);
    end
  end

  // Only positions below LOAD_LAT can stall; a nearer non-load writer shadows a load.
  always_comb begin
    nearestIsLoad = 1'b0;
    for (int p = LOAD_LAT - 1; p >= 0; p--) begin
      if (writesReg(cand[p], idReg)) nearestIsLoad = cand[p].load;
    end
    loadHazard = idEn && nearestIsLoad;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Multi-stage forwarding and load-use stall unit beside the ID/EX boundary.
// Optional FWD_STATS_EN adds a saturating stall-cycle counter output.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int AW       = 5,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_rs_en,
  input  logic            id_rt_en,
  input  logic            id_we,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_load,
  output logic            stall,
  output logic [SELW-1:0] fwd_a,
  output logic [SELW-1:0] fwd_b
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]     stall_cycles
`endif
);

  exSlot_t           exQ;
  exSlot_t           exD;
  fwdTag_t [DEPTH:1] srcQ;
  regAddr_t          idRs;
  regAddr_t          idRt;
  regAddr_t          idRd;
  logic              hazA;
  logic              hazB;
  logic              bubble;

  always_comb begin
    idRs         = '0;
    idRt         = '0;
    idRd         = '0;
    idRs[AW-1:0] = id_rs;
    idRt[AW-1:0] = id_rt;
    idRd[AW-1:0] = id_rd;
  end

  // flush squashes the ID instruction, so it also masks any stall request.
  assign stall  = id_valid && !flush && (hazA || hazB);
  assign bubble = stall || flush || !id_valid;

  // NOTE: every field gets a default before the conditional update, so no latch is inferred.
  always_comb begin
    exD = '0;
    if (!bubble) begin
      exD.tag.v    = 1'b1;
      exD.tag.we   = id_we;
      exD.tag.rd   = idRd;
      exD.tag.load = id_load;
      exD.rs       = idRs;
      exD.rsEn     = id_rs_en;
      exD.rt       = idRt;
      exD.rtEn     = id_rt_en;
    end
  end

  // NOTE: the whole shadow pipeline is reset (not just the v bits) so tags never
  // carry X into the comparators; non-blocking assignment makes each stage take
  // its predecessor's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exQ  <= '0;
      srcQ <= '0;
    end else begin
      exQ             <= exD;
      srcQ[SRC_EXMEM] <= exQ.tag;
      for (int k = SRC_EXMEM + 1; k <= DEPTH; k++) begin
        srcQ[k] <= srcQ[k-1];
      end
    end
  end

  fwd_match #(
    .DEPTH   (DEPTH),
    .LOAD_LAT(LOAD_LAT),
    .SELW    (SELW)
  ) uMatchRs (
    .exReg     (exQ.rs),
    .exEn      (exQ.tag.v && exQ.rsEn),
    .idReg     (idRs),
    .idEn      (id_rs_en),
    .exTag     (exQ.tag),
    .srcTags   (srcQ),
    .sel       (fwd_a),
    .loadHazard(hazA)
  );

  fwd_match #(
    .DEPTH   (DEPTH),
    .LOAD_LAT(LOAD_LAT),
    .SELW    (SELW)
  ) uMatchRt (
    .exReg     (exQ.rt),
    .exEn      (exQ.tag.v && exQ.rtEn),
    .idReg     (idRt),
    .idEn      (id_rt_en),
    .exTag     (exQ.tag),
    .srcTags   (srcQ),
    .sel       (fwd_b),
    .loadHazard(hazB)
  );

`ifdef FWD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
